// File: rtl/ef_gpio8_pulse_gen.sv
// rtl/ef_gpio8_pulse_gen.sv - GPIO output driver with per-pin base level and one-shot pulse timers
// io_out = base ^ active; a pulse inverts its pin for cmd_len cycles, then strobes done.
module ef_gpio8_pulse_gen #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_mask,
  input  logic [CNT_W-1:0] cmd_len,
  input  logic [WIDTH-1:0] bus_oe,
  output logic [WIDTH-1:0] io_oe,
  output logic [WIDTH-1:0] io_out,
  output logic [WIDTH-1:0] busy,
  output logic [WIDTH-1:0] done
);

  localparam logic [1:0] OP_SET    = 2'b00;
  localparam logic [1:0] OP_CLR    = 2'b01;
  localparam logic [1:0] OP_TOGGLE = 2'b10;
  localparam logic [1:0] OP_PULSE  = 2'b11;

  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] active;
  logic [WIDTH-1:0] done_q;
  logic [CNT_W-1:0] cnt [WIDTH];
  logic             accept;
  logic [CNT_W-1:0] len_eff;

  // Only a pulse that would retrigger a running timer has to wait.
  assign cmd_ready = ~((cmd_op == OP_PULSE) & (|(cmd_mask & active)));
  assign accept    = cmd_valid & cmd_ready;
  assign len_eff   = (cmd_len == '0) ? CNT_W'(1) : cmd_len;

  assign io_oe  = bus_oe;
  assign io_out = base ^ active;
  assign busy   = active;
  assign done   = done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      base   <= '0;
      active <= '0;
      done_q <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        done_q[i] <= 1'b0;
        if (active[i]) begin
          if (cnt[i] == CNT_W'(1)) begin
            active[i] <= 1'b0;
            done_q[i] <= 1'b1;
            cnt[i]    <= '0;
          end else begin
            cnt[i] <= cnt[i] - CNT_W'(1);
          end
        end
        // A pulse command never targets an active pin, so it cannot collide with the timer.
        if (accept && cmd_mask[i]) begin
          case (cmd_op)
            OP_SET:    base[i] <= 1'b1;
            OP_CLR:    base[i] <= 1'b0;
            OP_TOGGLE: base[i] <= ~base[i];
            OP_PULSE: begin
              active[i] <= 1'b1;
              cnt[i]    <= len_eff;
            end
            default:   base[i] <= base[i];
          endcase
        end
      end
    end
  end

endmodule
